// File: rtl/eight_bit_down_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// A host loads a start value over valid/ready, starts it, and may pause and resume it.
module eight_bit_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             load_fire;

  assign load_ready = (state != S_RUN);
  assign busy       = (state == S_RUN);
  assign done       = (state == S_DONE);
  assign load_fire  = load_valid && load_ready;

  // Zero is terminal: it raises tc instead of wrapping, and either reloads or ends a one-shot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      count  <= ZERO;
      reload <= ZERO;
      tc     <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load_fire) begin
        count  <= load_value;
        reload <= load_value;
      end
      case (state)
        S_IDLE: begin
          if (load_fire) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (start) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state <= S_ARMED;
          end else if (en) begin
            if (count != ZERO) begin
              count <= count - ONE;
            end else begin
              tc <= 1'b1;
              if (mode) begin
                count <= reload;
              end else begin
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (load_fire) begin
            state <= start ? S_RUN : S_ARMED;
          end else if (start) begin
            count <= reload;
            state <= S_RUN;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
